ham_serial_rx: RTL and testbench

Serial codeword receiver placed directly upstream of `ham_decoder`. It assembles 7-bit Hamming codewords from a framed, bit-serial stream and buffers completed words in a small show-ahead FIFO. It presents each word on a valid/ready interface, and `msg_out` drives `ham_decoder.message` directly. Frame, drop and abort statistics are kept in saturating counters.

---
 rtl/ham_serial_rx.sv | 165 ++++++++++++++++
 tb/tb_ham_serial_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ham_serial_rx.sv
// Bit-serial Hamming codeword receiver: frames 7-bit words from a sof-marked
// stream, buffers them in a show-ahead FIFO and keeps saturating statistics.
module ham_serial_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                            clock,
  input  logic                            reset_L,
  input  logic                            bit_valid,
  input  logic                            bit_in,
  input  logic                            sof,
  input  logic                            msg_ready,
  input  logic                            clear_counts,
  output logic [6:0]                      msg_out,
  output logic                            msg_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [CNT_W-1:0]                frame_count,
  output logic [CNT_W-1:0]                drop_count,
  output logic [CNT_W-1:0]                abort_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    if (clr) begin
      return {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      return cnt + CNT_W'(1);
    end else begin
      return cnt;
    end
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [5:0]       shreg_q, shreg_d;
  logic [6:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [6:0]       msg_out_q, msg_out_d;
  logic             msg_valid_q, msg_valid_d;
  logic [CNT_W-1:0] frame_q, frame_d, drop_q, drop_d, abort_q, abort_d;

  logic       push_s, abort_s, pop_s, full_s, push_ok_s, drop_s;
  logic [6:0] word_s;

  // Frame assembler: the first bit of a frame ends up in word bit 6.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    push_s  = 1'b0;
    abort_s = 1'b0;
    word_s  = {shreg_q, bit_in};
    case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          shreg_d = {5'b00000, bit_in};
          bcnt_d  = 3'd1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bit_valid && sof) begin
          abort_s = 1'b1;
          shreg_d = {5'b00000, bit_in};
          bcnt_d  = 3'd1;
        end else if (bit_valid && (bcnt_q == 3'd6)) begin
          push_s  = 1'b1;
          bcnt_d  = 3'd0;
          state_d = IDLE;
        end else if (bit_valid) begin
          shreg_d = {shreg_q[4:0], bit_in};
          bcnt_d  = bcnt_q + 3'd1;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = 3'd0;
      end
    endcase
  end

  // FIFO bookkeeping and the registered show-ahead head word.
  always_comb begin
    pop_s     = msg_valid_q & msg_ready;
    full_s    = (level_q == LW'(FIFO_DEPTH));
    push_ok_s = push_s & (~full_s | pop_s);
    drop_s    = push_s & full_s & ~pop_s;
    wr_ptr_d  = push_ok_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    msg_valid_d = (level_d != LW'(0));
    // A push only becomes the head when it lands in an empty (or emptying) FIFO.
    if (level_d == LW'(0)) begin
      msg_out_d = 7'h00;
    end else if (!msg_valid_q) begin
      msg_out_d = word_s;
    end else if (pop_s && (level_q == LW'(1))) begin
      msg_out_d = word_s;
    end else if (pop_s) begin
      msg_out_d = mem_q[rd_ptr_q + PW'(1)];
    end else begin
      msg_out_d = msg_out_q;
    end
    frame_d = cnt_next(frame_q, push_ok_s, clear_counts);
    drop_d  = cnt_next(drop_q, drop_s, clear_counts);
    abort_d = cnt_next(abort_q, abort_s, clear_counts);
  end

  // All state, including the word storage, with asynchronous reset.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      bcnt_q      <= 3'd0;
      shreg_q     <= 6'd0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      level_q     <= {LW{1'b0}};
      msg_out_q   <= 7'h00;
      msg_valid_q <= 1'b0;
      frame_q     <= {CNT_W{1'b0}};
      drop_q      <= {CNT_W{1'b0}};
      abort_q     <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 7'h00;
      end
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      msg_out_q   <= msg_out_d;
      msg_valid_q <= msg_valid_d;
      frame_q     <= frame_d;
      drop_q      <= drop_d;
      abort_q     <= abort_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= word_s;
      end
    end
  end

  assign msg_out     = msg_out_q;
  assign msg_valid   = msg_valid_q;
  assign fifo_level  = level_q;
  assign frame_count = frame_q;
  assign drop_count  = drop_q;
  assign abort_count = abort_q;

endmodule

// File: tb/tb_ham_serial_rx.sv
// Scoreboard bench for ham_serial_rx: expected words are queued as frames are
// sent and a forked monitor checks each accepted head word in order.
module tb_ham_serial_rx;

  logic       clock, reset_L, bit_valid, bit_in, sof, msg_ready, clear_counts;
  logic [6:0] msg_out;
  logic       msg_valid;
  logic [2:0] fifo_level;
  logic [2:0] frame_count, drop_count, abort_count;

  int         errors = 0;
  int         checks = 0;
  logic [6:0] sb[$];

  ham_serial_rx #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clock(clock), .reset_L(reset_L), .bit_valid(bit_valid), .bit_in(bit_in),
    .sof(sof), .msg_ready(msg_ready), .clear_counts(clear_counts),
    .msg_out(msg_out), .msg_valid(msg_valid), .fifo_level(fifo_level),
    .frame_count(frame_count), .drop_count(drop_count), .abort_count(abort_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    bit_valid = 1'b1;
    bit_in    = b;
    sof       = s;
    tick();
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] w, input int max_gap);
    for (int i = 6; i >= 0; i--) begin
      send_bit(w[i], i == 6);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic send_six(input logic [6:0] w);
    for (int i = 6; i >= 1; i--) send_bit(w[i], i == 6);
  endtask

  task automatic clear();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
    check(name, sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, msg_valid, 1'b0);
    check({tag, "_out"}, msg_out, 7'h00);
    check({tag, "_level"}, fifo_level, 3'd0);
    check({tag, "_frame"}, frame_count, 3'd0);
    check({tag, "_drop"}, drop_count, 3'd0);
    check({tag, "_abort"}, abort_count, 3'd0);
  endtask

  task automatic monitor();
    logic [6:0] exp;
    forever begin
      @(negedge clock);
      if (reset_L && msg_valid && msg_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", msg_out, 7'h7f ^ msg_out);
        end else begin
          exp = sb.pop_front();
          check("head_word", msg_out, exp);
        end
      end
    end
  endtask

  initial begin
    reset_L = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sof = 1'b0;
    msg_ready = 1'b0; clear_counts = 1'b0;
    fork
      monitor();
    join_none
    #2;
    check_zero_outputs("por");
    tick(); tick();
    reset_L = 1'b1;
    tick();

    // Single frame, held, then one-cycle pop.
    send_frame(7'h59, 0);
    check("single_valid", msg_valid, 1'b1);
    check("single_out", msg_out, 7'h59);
    check("single_level", fifo_level, 3'd1);
    check("single_frame", frame_count, 3'd1);
    sb.push_back(7'h59);
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    check("pop_valid", msg_valid, 1'b0);
    check("pop_out", msg_out, 7'h00);
    check("pop_sb", sb.size(), 0);

    // Asynchronous reset with a stored word and a partial frame.
    send_frame(7'h33, 0);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    check("pre_rst_valid", msg_valid, 1'b1);
    reset_L = 1'b0;
    #2;
    check_zero_outputs("midrst");
    tick();
    reset_L = 1'b1;
    send_frame(7'h59, 0);
    check("postrst_abort", abort_count, 3'd0);
    check("postrst_frame", frame_count, 3'd1);
    check("postrst_out", msg_out, 7'h59);
    sb.push_back(7'h59);
    msg_ready = 1'b1;
    wait_drain("postrst_drain");

    // Stray bit in IDLE, then gapped frame.
    send_bit(1'b1, 1'b0);
    tick();
    sb.push_back(7'h59);
    send_frame(7'h59, 5);
    wait_drain("gapped_drain");
    check("gapped_frame", frame_count, 3'd2);

    // Abort by a new sof.
    clear();
    check("clr_frame", frame_count, 3'd0);
    sb.push_back(7'h02);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_frame(7'h02, 0);
    wait_drain("abort_drain");
    check("abort_abort", abort_count, 3'd1);
    check("abort_frame", frame_count, 3'd1);

    // Overflow: fifth word dropped.
    msg_ready = 1'b0;
    clear();
    for (int i = 1; i <= 5; i++) send_frame(7'(i), 0);
    for (int i = 1; i <= 4; i++) sb.push_back(7'(i));
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_drop", drop_count, 3'd1);
    check("ovf_frame", frame_count, 3'd4);
    check("ovf_head", msg_out, 7'h01);

    // Full FIFO: completion coincides with a pop.
    send_six(7'h06);
    msg_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    msg_ready = 1'b0;
    sb.push_back(7'h06);
    check("fullpop_drop", drop_count, 3'd1);
    check("fullpop_level", fifo_level, 3'd4);
    check("fullpop_frame", frame_count, 3'd5);
    check("fullpop_head", msg_out, 7'h02);

    // Clear coincides with a (dropped) completion.
    send_six(7'h07);
    clear_counts = 1'b1;
    send_bit(1'b1, 1'b0);
    clear_counts = 1'b0;
    check("clr_frame2", frame_count, 3'd0);
    check("clr_drop", drop_count, 3'd0);
    check("clr_abort", abort_count, 3'd0);
    check("clr_level", fifo_level, 3'd4);

    msg_ready = 1'b1;
    wait_drain("ovf_drain");
    tick();
    check("drained_level", fifo_level, 3'd0);
    check("drained_valid", msg_valid, 1'b0);
    check("drained_out", msg_out, 7'h00);

    // Saturation of the 3-bit frame counter.
    clear();
    for (int i = 0; i < 9; i++) begin
      sb.push_back(7'h10 + 7'(i));
      send_frame(7'h10 + 7'(i), 0);
    end
    wait_drain("sat_drain");
    check("sat_frame", frame_count, 3'd7);
    check("sat_level", fifo_level, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
